pf_tile_fetch: RTL
==================

# pf_tile_fetch

Playfield tile fetcher that sits directly upstream of the playfield tile RAM. For each scanline it reads tile entries from the four byte-lane playfield RAMs and fetches 4bpp row data from graphics ROM over a req/ack handshake. It then writes up to 128 palette-tagged pixels into the line buffer. Scroll and wrap handling live here, so downstream logic sees screen-space pixels only.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- line_start  in  1  one-cycle pulse; latch inputs and begin fetching a line
- vpos  in  8  scanline number
- scroll_x  in  8  horizontal scroll (pixels)
- scroll_y  in  8  vertical scroll (pixels)
- vram_a  out  8  tile RAM address {ty[3:0], tx[3:0]}
- vram_ce_n  out  1  tile RAM chip enable, active-low
- vram_we_n  out  1  tile RAM write enable, active-low; held 1 (read-only client)
- vram_d  in  32  {lane3, lane2, lane1, lane0} read data
- rom_req  out  1  graphics ROM request
- rom_addr  out  17  {code[13:0], row[2:0]}
- rom_ack  in  1  ROM data valid
- rom_data  in  32  8 pixels × 4 bits; [31:28] leftmost when unflipped
- lb_we  out  1  line buffer write strobe
- lb_x  out  7  screen x, 0..127
- lb_color  out  8  {palette[3:0], pixel[3:0]}
- lb_prio  out  1  attribute priority bit
- busy  out  1  line fetch in progress
- done  out  1  one-cycle pulse at end of line

## Operation
- Tile entry, per RAM address: code = {lane1, lane0}, with only code[13:0] used. Attribute = lane2: [3:0] palette, [5] flipx, [6] flipy, [7] priority. lane3 is ignored.
- Latched at line_start:
  - y = vpos + scroll_y (mod 256).
  - ty = y[6:3] (16-tile wrap).
  - row = y[2:0].
  - fine = scroll_x[2:0].
  - tx0 = scroll_x[6:3].
- Tile loop i = 0..16 (17 tiles):
  - tx = (tx0 + i) mod 16.
  - Effective row = flipy ? 7-row : row.
- States:
  - IDLE: busy=0. On line_start, latch inputs, set i=0 → VRD.
  - VRD: drive vram_a, vram_ce_n=0 → VLAT.
  - VLAT: vram_ce_n stays 0; register vram_d → ROM.
  - ROM: rom_req=1 with rom_addr stable. On the cycle rom_ack=1, capture rom_data and drop req next cycle → EMIT.
  - EMIT: 8 cycles, p=0..7.
    - Source nibble index = flipx ? 7-p : p, counted from the left.
    - Pixel x = 8i + p − fine, computed in 9-bit signed arithmetic.
    - lb_we=1 only when 0 ≤ x ≤ 127 and the nibble is nonzero (0 is transparent). lb_x = x[6:0].
    - After p=7: i==16 → DONE, else i+1 → VRD.
  - DONE: done=1 for one cycle → IDLE.
- rom_ack is ignored while rom_req=0.
- line_start while busy aborts the current line immediately:
  - rom_req drops.
  - Inputs are re-latched and the FSM goes to VRD with i=0.
  - No done pulse is issued for the aborted line.
  - An outstanding ack for the aborted request is the ROM's responsibility; the fetcher ignores acks outside ROM state.

## Timing
- Reset values: IDLE, vram_ce_n=1, vram_we_n=1, vram_a=0, rom_req=0, rom_addr=0, lb_we=0, lb_x=0, lb_color=0, lb_prio=0, busy=0, done=0.
- line_start in cycle N → VRD in N+1 (vram_ce_n low in N+1). busy=1 from N+1 until the cycle done pulses; busy=0 on the done cycle.
- vram_d is sampled at the end of VLAT, i.e. the second cycle the address is held.
- Minimum per tile is 11 cycles: VRD, VLAT, ROM with same-cycle ack, 8×EMIT. Each ack wait cycle adds one.
- Minimum line is 187 cycles from the first VRD to the last EMIT; done is the following cycle.
- lb_* outputs are registered: the write for EMIT cycle p appears one cycle later. No gaps occur within the 8 pixels.

## Test plan
- **Basic fetch:**
  - Stimulus: scroll 0/0, vpos=0. Entry at addr 0x00: code 0x0005, attr 0x03. ROM acks same cycle with 0x12345678 at rom_addr 0x00028.
  - Required: writes x=0..7 with lb_color 0x31..0x38, lb_prio=0, and 17 rom_req transactions.
- **Flip:**
  - Stimulus: attr 0x63, vpos=2.
  - Required: rom_addr row=5, and x=0..7 gets 0x38, 0x37, …, 0x31.
- **Fine scroll / clip:**
  - Stimulus: scroll_x=3, all-nonzero data.
  - Required: exactly 128 writes, x=0 from tile 0 nibble 3. Tile 0 nibbles 0..2 and tile 16 nibbles 3..7 are not written.
- **Wrap:**
  - Stimulus: scroll_x=0xF8, scroll_y=0x7C, vpos=0x0A.
  - Required: y=0x86, so ty=0 and row=6. vram_a sequence 0x0F, 0x00, 0x01, …, 0x0F.
- **Handshake:**
  - Stimulus: ack delayed 5 cycles, with transparent nibbles 0.
  - Required: rom_req and rom_addr held stable; no write for zero nibbles; line length is 187 + 17×5 cycles.
- **Abort / reset:**
  - Stimulus: line_start mid-EMIT of tile 4.
  - Required: restart at vram_a of tile 0 next cycle; only one done pulse. Reset asserted in ROM state gives all outputs at reset values the next cycle.

Source files
------------

// File: rtl/pf_tile_fetch.sv
// Playfield tile fetcher: walks 17 tiles per scanline, reads tile entries and
// 4bpp ROM rows, and streams palette-tagged, scroll-corrected pixels to the line buffer.
module pf_tile_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  vpos,
  input  logic [7:0]  scroll_x,
  input  logic [7:0]  scroll_y,
  output logic [7:0]  vram_a,
  output logic        vram_ce_n,
  output logic        vram_we_n,
  input  logic [31:0] vram_d,
  output logic        rom_req,
  output logic [16:0] rom_addr,
  input  logic        rom_ack,
  input  logic [31:0] rom_data,
  output logic        lb_we,
  output logic [6:0]  lb_x,
  output logic [7:0]  lb_color,
  output logic        lb_prio,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_VRD  = 3'd1;
  localparam logic [2:0] S_VLAT = 3'd2;
  localparam logic [2:0] S_ROM  = 3'd3;
  localparam logic [2:0] S_EMIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [4:0] LAST_TILE = 5'd16;

  logic [2:0]  state_q, state_d;
  logic [4:0]  tile_q, tile_d;
  logic [2:0]  pix_q, pix_d;
  logic [3:0]  ty_q, ty_d;
  logic [2:0]  row_q, row_d;
  logic [2:0]  fine_q, fine_d;
  logic [3:0]  tx0_q, tx0_d;
  logic [13:0] code_q, code_d;
  logic [7:0]  attr_q, attr_d;
  logic [31:0] data_q, data_d;
  logic        lb_we_q, lb_we_d;
  logic [6:0]  lb_x_q, lb_x_d;
  logic [7:0]  lb_color_q, lb_color_d;
  logic        lb_prio_q, lb_prio_d;

  logic [7:0]        y_sum;
  logic [3:0]        tx;
  logic [2:0]        eff_row;
  logic [2:0]        src_idx;
  logic [3:0]        nibble;
  logic signed [8:0] pix_x;
  logic              in_range;
  logic              unused_bits;

  assign y_sum   = vpos + scroll_y;
  assign tx      = tx0_q + tile_q[3:0];
  assign eff_row = attr_q[6] ? ~row_q : row_q;
  assign src_idx = attr_q[5] ? ~pix_q : pix_q;
  assign nibble  = data_q[5'd31 - {src_idx, 2'b00} -: 4];

  // Screen x = 8*tile + p - fine; bit 8 is the sign, bit 7 set means >= 128.
  assign pix_x    = $signed({1'b0, tile_q, pix_q}) - $signed({6'b0, fine_q});
  assign in_range = ~pix_x[8] & ~pix_x[7];

  assign unused_bits = ^{vram_d[31:24], vram_d[15:14], y_sum[7], scroll_x[7]};

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no
    // path through this block leaves a signal unassigned and infers a latch.
    state_d    = state_q;
    tile_d     = tile_q;
    pix_d      = pix_q;
    ty_d       = ty_q;
    row_d      = row_q;
    fine_d     = fine_q;
    tx0_d      = tx0_q;
    code_d     = code_q;
    attr_d     = attr_q;
    data_d     = data_q;
    lb_we_d    = 1'b0;
    lb_x_d     = lb_x_q;
    lb_color_d = lb_color_q;
    lb_prio_d  = lb_prio_q;

    case (state_q)
      S_VRD: state_d = S_VLAT;
      S_VLAT: begin
        code_d  = vram_d[13:0];
        attr_d  = vram_d[23:16];
        state_d = S_ROM;
      end
      S_ROM: begin
        if (rom_ack) begin
          data_d  = rom_data;
          pix_d   = 3'd0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        lb_we_d    = in_range && (nibble != 4'd0);
        lb_x_d     = pix_x[6:0];
        lb_color_d = {attr_q[3:0], nibble};
        lb_prio_d  = attr_q[7];
        pix_d      = pix_q + 3'd1;
        if (pix_q == 3'd7) begin
          if (tile_q == LAST_TILE) begin
            state_d = S_DONE;
          end else begin
            tile_d  = tile_q + 5'd1;
            state_d = S_VRD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new line always wins: it restarts from tile 0 and kills any pending write.
    if (line_start) begin
      ty_d    = y_sum[6:3];
      row_d   = y_sum[2:0];
      fine_d  = scroll_x[2:0];
      tx0_d   = scroll_x[6:3];
      tile_d  = 5'd0;
      pix_d   = 3'd0;
      lb_we_d = 1'b0;
      state_d = S_VRD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tile_q     <= '0;
      pix_q      <= '0;
      ty_q       <= '0;
      row_q      <= '0;
      fine_q     <= '0;
      tx0_q      <= '0;
      code_q     <= '0;
      attr_q     <= '0;
      data_q     <= '0;
      lb_we_q    <= 1'b0;
      lb_x_q     <= '0;
      lb_color_q <= '0;
      lb_prio_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge
      // values, independent of statement order.
      state_q    <= state_d;
      tile_q     <= tile_d;
      pix_q      <= pix_d;
      ty_q       <= ty_d;
      row_q      <= row_d;
      fine_q     <= fine_d;
      tx0_q      <= tx0_d;
      code_q     <= code_d;
      attr_q     <= attr_d;
      data_q     <= data_d;
      lb_we_q    <= lb_we_d;
      lb_x_q     <= lb_x_d;
      lb_color_q <= lb_color_d;
      lb_prio_q  <= lb_prio_d;
    end
  end

  assign vram_a    = {ty_q, tx};
  assign vram_ce_n = !((state_q == S_VRD) || (state_q == S_VLAT));
  assign vram_we_n = 1'b1;
  assign rom_req   = (state_q == S_ROM);
  assign rom_addr  = {code_q, eff_row};
  assign lb_we     = lb_we_q;
  assign lb_x      = lb_x_q;
  assign lb_color  = lb_color_q;
  assign lb_prio   = lb_prio_q;
  assign busy      = (state_q == S_VRD) || (state_q == S_VLAT) ||
                     (state_q == S_ROM) || (state_q == S_EMIT);
  assign done      = (state_q == S_DONE);

endmodule
